// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO and launch sequencer feeding tx_module.
// Bytes are queued from the host side and handed to tx_module one at a time
// using a start/busy handshake. An entry stays in the FIFO until its
// character has finished transmitting.
module tx_fifo_ctrl #(
  parameter int unsigned MAX_UART_DATA_W = 8,
  parameter int unsigned FIFO_DEPTH      = 16   // power of 2, >= 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            tx_en_i,
  input  logic                            wr_en_i,
  input  logic [MAX_UART_DATA_W-1:0]      wr_data_i,
  input  logic                            tx_busy_i,
  output logic                            tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]      tx_data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            overflow_o
);

  localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW      = AddrWidth + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_POP    = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic                       tx_start_q, tx_start_d;
  logic                       pop;
  logic                       push;

  logic [MAX_UART_DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AddrWidth-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]            level_q, level_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       overflow_q, overflow_d;

  // Full is judged on the registered flag, so a push during a pop cycle
  // at full is still rejected.
  assign push = wr_en_i && !full_q;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: launch, wait for busy, wait for done, retire.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!empty_q && tx_en_i) state_d = ST_REQ;
      ST_REQ:    if (tx_busy_i)           state_d = ST_ACTIVE;
      ST_ACTIVE: if (!tx_busy_i)          state_d = ST_POP;
      ST_POP:                             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: start is registered so it is high exactly while in REQ.
  always_comb begin
    tx_start_d = (state_d == ST_REQ);
    pop        = (state_q == ST_POP);
  end

  // Pointer, level and flag next-state computation.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AddrWidth'(1);
    level_d    = level_q + LvlW'(push) - LvlW'(pop);
    full_d     = (level_d == LvlW'(FIFO_DEPTH));
    empty_d    = (level_d == LvlW'(0));
    overflow_d = wr_en_i && full_q;
  end

  // Control registers; reset discards any queued data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_start_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since level gates their use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head of FIFO; rd_ptr only moves in POP so data holds through the transfer.
  assign tx_data_o  = mem_q[rd_ptr_q];
  assign tx_start_o = tx_start_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Self-checking bench for tx_fifo_ctrl: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_tx_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          tx_en_i;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          tx_busy_i;
  logic          tx_start_o;
  logic [DW-1:0] tx_data_o;
  logic          full_o;
  logic          empty_o;
  logic [4:0]    level_o;
  logic          overflow_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tx_fifo_ctrl #(.MAX_UART_DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_en_i    (tx_en_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .tx_busy_i  (tx_busy_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst, wr, en, busy;
    logic [7:0] wdata;
    logic       e_start, e_empty, e_full, e_ovf;
    logic [4:0] e_level;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic wr, logic [7:0] wd, logic en, logic busy,
                              logic es, logic ee, logic ef, logic eo, logic [4:0] el,
                              logic cd, logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wdata = wd; v.en = en; v.busy = busy;
    v.e_start = es; v.e_empty = ee; v.e_full = ef; v.e_ovf = eo; v.e_level = el;
    v.chk_data = cd; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [7:0] wd,
                       input logic en, input logic busy);
    rst_i = rst; wr_en_i = wr; wr_data_i = wd; tx_en_i = en; tx_busy_i = busy;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.rst, v.wr, v.wdata, v.en, v.busy);
    step();
    chk($sformatf("vec%0d start", idx), int'(tx_start_o), int'(v.e_start));
    chk($sformatf("vec%0d empty", idx), int'(empty_o),    int'(v.e_empty));
    chk($sformatf("vec%0d full", idx),  int'(full_o),     int'(v.e_full));
    chk($sformatf("vec%0d ovf", idx),   int'(overflow_o), int'(v.e_ovf));
    chk($sformatf("vec%0d level", idx), int'(level_o),    int'(v.e_level));
    if (v.chk_data) chk($sformatf("vec%0d data", idx), int'(tx_data_o), int'(v.e_data));
  endtask

  // Push n bytes starting at value base with launching disabled.
  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 8'(base + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Randomized run state
  logic [7:0] q[$];
  int pop_cd, rsp, rsp_cnt;
  logic exp_ovf;

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte transfer with busy handshake.
    vecs.push_back(mk(1,0,8'h00,0,0, 0,1,0,0,5'd0, 0,8'h00));
    vecs.push_back(mk(0,1,8'hA5,1,0, 0,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,0, 1,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,0, 1,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,1, 0,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,1, 0,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,1, 0,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,0, 0,0,0,0,5'd1, 1,8'hA5));
    vecs.push_back(mk(0,0,8'h00,1,0, 0,1,0,0,5'd0, 0,8'h00));
    vecs.push_back(mk(0,0,8'h00,1,0, 0,1,0,0,5'd0, 0,8'h00));
    // Fill to full with launching disabled, then overflow.
    vecs.push_back(mk(1,0,8'h00,0,0, 0,1,0,0,5'd0, 0,8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0,1,8'(i),0,0, 0,0,(i == 15),0,5'(i+1), 1,8'h00));
    vecs.push_back(mk(0,1,8'hEE,0,0, 0,0,1,1,5'd16, 1,8'h00));
    vecs.push_back(mk(0,0,8'h00,0,0, 0,0,1,0,5'd16, 1,8'h00));
    vecs.push_back(mk(0,0,8'h00,0,0, 0,0,1,0,5'd16, 1,8'h00));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Push coinciding with POP at level 5: level holds.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    fill(5, 8'h10);
    step();
    chk("l5 level", int'(level_o), 5);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("l5 start", int'(tx_start_o), 1);
    chk("l5 data", int'(tx_data_o), 8'h10);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
    chk("l5 start off", int'(tx_start_o), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0); step();
    chk("l5 level after", int'(level_o), 5);
    chk("l5 ovf", int'(overflow_o), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("l5 head", int'(tx_data_o), 8'h11);
    chk("l5 level hold", int'(level_o), 5);

    // Push coinciding with POP at full: rejected, level drops to 15.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    fill(16, 8'h30);
    step();
    chk("f16 full", int'(full_o), 1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("f16 start", int'(tx_start_o), 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0); step();
    chk("f16 level", int'(level_o), 15);
    chk("f16 ovf", int'(overflow_o), 1);
    chk("f16 full after", int'(full_o), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); step();
    chk("f16 ovf pulse", int'(overflow_o), 0);
    chk("f16 head", int'(tx_data_o), 8'h31);

    // Reset while ACTIVE with 3 queued, then a clean restart from pointer 0.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    fill(3, 8'h60);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); step();
    chk("rst active start", int'(tx_start_o), 0);
    chk("rst active level", int'(level_o), 3);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1); step();
    chk("rst start", int'(tx_start_o), 0);
    chk("rst empty", int'(empty_o), 1);
    chk("rst level", int'(level_o), 0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("rst idle start", int'(tx_start_o), 0);
    drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("restart start", int'(tx_start_o), 1);
    chk("restart data", int'(tx_data_o), 8'h77);
    chk("restart level", int'(level_o), 1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); step();
    step();
    chk("restart done", int'(level_o), 0);
    chk("restart empty", int'(empty_o), 1);

    // Randomized run against the queue model with a busy-responder.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); step();
    q.delete();
    pop_cd = 0; rsp = 0; rsp_cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // Responder: react to start, raise busy, hold, drop.
      case (rsp)
        0: if (tx_start_o) begin
             chk("rnd start nonempty", int'(q.size() != 0), 1);
             if (q.size() != 0) chk("rnd start data", int'(tx_data_o), int'(q[0]));
             rsp_cnt = int'($urandom_range(0, 2));
             if (rsp_cnt == 0) begin
               tx_busy_i = 1'b1; rsp = 2; rsp_cnt = int'($urandom_range(1, 4));
             end else rsp = 1;
           end
        1: begin
             rsp_cnt--;
             if (rsp_cnt == 0) begin
               tx_busy_i = 1'b1; rsp = 2; rsp_cnt = int'($urandom_range(1, 4));
             end
           end
        default: begin
             rsp_cnt--;
             if (rsp_cnt == 0) begin
               tx_busy_i = 1'b0; rsp = 0; pop_cd = 2;
             end
           end
      endcase
      rst_i     = 1'b0;
      wr_en_i   = ($urandom_range(0, 99) < (((cyc / 100) % 2 == 1) ? 70 : 20));
      wr_data_i = 8'($urandom);
      tx_en_i   = ($urandom_range(0, 7) != 0);

      // Model the coming edge.
      exp_ovf = wr_en_i && (q.size() == DEPTH);
      if (pop_cd != 0) begin
        pop_cd--;
        if (pop_cd == 0 && q.size() != 0) void'(q.pop_front());
      end
      if (wr_en_i && !exp_ovf) q.push_back(wr_data_i);
      step();

      chk("rnd level", int'(level_o), q.size());
      chk("rnd empty", int'(empty_o), int'(q.size() == 0));
      chk("rnd full",  int'(full_o),  int'(q.size() == DEPTH));
      chk("rnd ovf",   int'(overflow_o), int'(exp_ovf));
      if (q.size() != 0) chk("rnd head", int'(tx_data_o), int'(q[0]));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
